spi_device_rx_mlane: RTL and testbench
======================================

// Module: spi_device_rx_mlane
// PURPOSE
//  Parametrised SPI device-side receiver: deserialises 1/2/4-lane (single/dual/quad) data sampled on sclk
//  into DATA_W-bit words of programmable length and buffers them in a FIFO with valid/ready output.
//  Sits between the SPI pad interface and the SPI device controller FSM, which programs word length/mode.
// PARAMETERS
//  DATA_W      32  width of assembled word / output data
//  CNT_W       8   width of bit-cycle counter and counter_in
//  FIFO_DEPTH  4   output FIFO entries (power of 2, >=2)
//  RST_TGT     7   counter target after reset (8 single-lane cycles = command byte)
// PORTS
//  sclk            in   1       SPI clock; all state changes on posedge
//  cs              in   1       chip-select, active-high synchronous reset of the whole block
//  sdi             in   4       serial data lanes {sdi3,sdi2,sdi1,sdi0}
//  mode_in         in   2       lane mode for next word: 0=single(sdi0) 1=dual(sdi1:0) 2=quad; 3 treated as quad
//  counter_in      in   CNT_W   target = sample cycles per word minus 1
//  counter_in_upd  in   1       load counter_in/mode_in and (re)start reception
//  data            out  DATA_W  FIFO head word
//  data_valid      out  1       FIFO non-empty
//  data_ready      in   1       consumer accepts head word when data_valid && data_ready
//  fifo_count      out  clog2(FIFO_DEPTH+1)  occupied entries
//  overflow        out  1       sticky: a completed word was dropped (FIFO full)
// BEHAVIOUR
//  Reset (cs=1 at posedge sclk): counter=0, target=RST_TGT, mode=single, running=1, shift reg=0,
//   FIFO empty, data=0, data_valid=0, fifo_count=0, overflow=0. cs overrides all other inputs.
//  States: RUN (running=1) / IDLE (running=0). Reset enters RUN.
//  RUN, each posedge: shift reg <= {sr[DATA_W-L-1:0], lanes}, L=1/2/4, MSB-first;
//   lane order quad {sdi3..sdi0}, dual {sdi1,sdi0}, single {sdi0}. Bits shifted past DATA_W lost.
//  counter!=target: counter++. counter==target (final sample): assembled word incl. current
//   sample pushed to FIFO; shift reg<=0; counter<=0; -> IDLE.
//  IDLE: no sampling; counter, shift reg hold. Only counter_in_upd or cs leaves IDLE.
//  counter_in_upd=1: current-edge sample/completion evaluated with OLD target/mode first (may push);
//   then target<=counter_in, mode<=mode_in, counter<=0, running<=1; an incomplete partial word is
//   discarded (shift reg<=0). New mode applies from next edge.
//  counter_in=0: one-sample word (L bits, zero-extended).
//  Latency: word visible on data/data_valid the edge after its final sample (push into empty FIFO).
//  FIFO: push on completion; pop on data_valid&&data_ready. Full & push & no pop: word dropped,
//   overflow<=1 (sticky until cs). Full & push & pop same edge: both accepted, count unchanged.
//   Empty & pop impossible (data_valid=0). data is head entry, 0 when empty.
//  Counter arithmetic CNT_W-bit unsigned; never wraps (reset to 0 on completion).
// TESTING
//  1 cs pulse, then 8 edges single, sdi0=1,0,1,0,0,1,0,1 -> next edge data=0x000000A5, valid=1, count=1.
//  2 upd counter_in=7 mode=2, 8 edges quad nibbles 1..8 -> data=0x12345678; IDLE afterwards, no further push.
//  3 upd counter_in=3 mode=1, dual pairs 3,2,1,0 -> data=0x000000E4.
//  4 ready=0, DEPTH=4, 5 words 0x11..0x55 -> count=4, overflow=1, pops yield 0x11,0x22,0x33,0x44.
//  5 FIFO full, ready=1 on final-sample edge -> 0x11 popped, new word pushed, count stays 4, overflow=0.
//  6 cs=1 mid-quad-word (after 3 nibbles) -> all outputs reset values; next 8 single edges give byte.

Source files
------------

// File: rtl/spi_device_rx_mlane.sv
// SPI device-side receiver: assembles 1/2/4-lane samples taken on sclk into words of
// programmable length and queues them in a small FIFO with a valid/ready output.
module spi_device_rx_mlane #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_TGT    = 7
) (
    input  logic                              sclk,
    input  logic                              cs,
    input  logic [3:0]                        sdi,
    input  logic [1:0]                        mode_in,
    input  logic [CNT_W-1:0]                  counter_in,
    input  logic                              counter_in_upd,
    output logic [DATA_W-1:0]                 data,
    output logic                              data_valid,
    input  logic                              data_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow,
    output logic                              state_dbg
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    // Handshake: a head word transfers on any sclk edge where data_valid && data_ready.
    typedef enum logic {ST_RUN = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_tgt;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_sr;
    logic [DATA_W-1:0]   w_sample;
    logic                w_final;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_rd;
    logic [AW-1:0]       r_wr;
    logic [CW-1:0]       r_count;
    logic                r_overflow;
    logic                w_full;
    logic                w_pop;
    logic                w_wr_en;

    always_comb begin
        w_sample = '0;
        case (r_mode)
            2'd0:    w_sample = {r_sr[DATA_W-2:0], sdi[0]};
            2'd1:    w_sample = {r_sr[DATA_W-3:0], sdi[1:0]};
            default: w_sample = {r_sr[DATA_W-5:0], sdi};
        endcase
    end

    assign w_final = (r_state == ST_RUN) && (r_cnt == r_tgt);

    always_ff @(posedge sclk) begin
        if (cs) r_state <= ST_RUN;
        else    r_state <= w_state_nxt;
    end

    // Reprogramming wins over completion: a word finishing on the update edge is still pushed.
    always_comb begin
        w_state_nxt = r_state;
        if (counter_in_upd)  w_state_nxt = ST_RUN;
        else if (w_final)    w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge sclk) begin
        if (cs) begin
            r_cnt  <= '0;
            r_tgt  <= CNT_W'(RST_TGT);
            r_mode <= 2'd0;
            r_sr   <= '0;
        end else if (counter_in_upd) begin
            r_cnt  <= '0;
            r_tgt  <= counter_in;
            r_mode <= mode_in;
            r_sr   <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_final) begin
                r_cnt <= '0;
                r_sr  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_sr  <= w_sample;
            end
        end
    end

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = (r_count != '0) && data_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_wr_en = w_final && (!w_full || w_pop);

    always_ff @(posedge sclk) begin
        if (!cs && w_wr_en) r_mem[r_wr] <= w_sample;
    end

    always_ff @(posedge sclk) begin
        if (cs) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + AW'(1);
            if (w_pop)   r_rd <= r_rd + AW'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_final && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign data       = (r_count != '0) ? r_mem[r_rd] : '0;
    assign data_valid = (r_count != '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign state_dbg  = (r_state == ST_RUN);

endmodule

// File: tb/tb_spi_device_rx_mlane.sv
// Bench for spi_device_rx_mlane: directed scenarios plus random traffic, every edge
// compared against a word-level behavioural model of the receiver and its FIFO.
module tb_spi_device_rx_mlane;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH+1);

    logic              sclk = 1'b0;
    logic              cs = 1'b1;
    logic [3:0]        sdi = '0;
    logic [1:0]        mode_in = '0;
    logic [CNT_W-1:0]  counter_in = '0;
    logic              counter_in_upd = 1'b0;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              data_ready = 1'b0;
    logic [CW-1:0]     fifo_count;
    logic              overflow;
    logic              state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_acc;
    int                m_cnt, m_tgt, m_mode;
    bit                m_run, m_ovf;

    spi_device_rx_mlane #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .RST_TGT(7)) dut (
        .sclk(sclk), .cs(cs), .sdi(sdi), .mode_in(mode_in), .counter_in(counter_in),
        .counter_in_upd(counter_in_upd), .data(data), .data_valid(data_valid),
        .data_ready(data_ready), .fifo_count(fifo_count), .overflow(overflow),
        .state_dbg(state_dbg)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level view: each sample appends L bits to the word; the word closes after target+1 samples.
    task automatic model_edge();
        int        lanes;
        logic [3:0] v;
        bit        push, pop;
        logic [DATA_W-1:0] word;
        if (cs) begin
            exp_q.delete();
            m_acc = '0; m_cnt = 0; m_tgt = 7; m_mode = 0; m_run = 1; m_ovf = 0;
            return;
        end
        pop  = (exp_q.size() > 0) && data_ready;
        push = 0;
        word = '0;
        if (m_run) begin
            lanes = (m_mode == 0) ? 1 : (m_mode == 1) ? 2 : 4;
            v = sdi & 4'((1 << lanes) - 1);
            word = (m_acc << lanes) | DATA_W'(v);
            if (m_cnt == m_tgt) begin
                push = 1; m_acc = '0; m_cnt = 0; m_run = 0;
            end else begin
                m_acc = word; m_cnt++;
            end
        end
        if (counter_in_upd) begin
            m_tgt = int'(counter_in); m_mode = int'(mode_in); m_cnt = 0; m_run = 1; m_acc = '0;
        end
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(word);
            else m_ovf = 1;
        end
    endtask

    task automatic compare();
        chk("data", data, (exp_q.size() > 0) ? exp_q[0] : '0);
        chk("data_valid", 32'(data_valid), 32'(exp_q.size() > 0));
        chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("running", 32'(state_dbg), 32'(m_run));
    endtask

    task automatic step();
        @(posedge sclk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic upd(input int cin, input int md);
        counter_in = CNT_W'(cin); mode_in = 2'(md); counter_in_upd = 1'b1;
        step();
        counter_in_upd = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sdi = {3'b000, b[i]};
            step();
        end
    endtask

    task automatic pulse_cs();
        cs = 1'b1; step(); cs = 1'b0;
    endtask

    initial begin
        logic [7:0] bytes [5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // 1: reset, then a single-lane command byte
        step();
        chk("rst_data", data, 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        cs = 1'b0;
        send_byte(8'hA5);
        chk("t1_data", data, 32'h000000A5);
        chk("t1_valid", 32'(data_valid), 32'h1);
        chk("t1_count", 32'(fifo_count), 32'h1);
        data_ready = 1'b1; step(); data_ready = 1'b0;

        // 2: quad word, then idle
        upd(7, 2);
        for (int n = 1; n <= 8; n++) begin
            sdi = 4'(n); step();
        end
        chk("t2_data", data, 32'h12345678);
        for (int n = 0; n < 4; n++) begin
            sdi = 4'hF; step();
        end
        chk("t2_idle_count", 32'(fifo_count), 32'h1);
        chk("t2_idle_run", 32'(state_dbg), 32'h0);
        data_ready = 1'b1; step(); data_ready = 1'b0;

        // 3: dual word
        upd(3, 1);
        for (int n = 3; n >= 0; n--) begin
            sdi = 4'(n); step();
        end
        chk("t3_data", data, 32'h000000E4);
        data_ready = 1'b1; step(); data_ready = 1'b0;

        // one-sample quad word
        upd(0, 2);
        sdi = 4'hB; step();
        chk("t3b_data", data, 32'h0000000B);
        data_ready = 1'b1; step(); data_ready = 1'b0;

        // 4: overflow with consumer stalled
        for (int w = 0; w < 5; w++) begin
            upd(7, 0); send_byte(bytes[w]);
        end
        chk("t4_count", 32'(fifo_count), 32'h4);
        chk("t4_ovf", 32'(overflow), 32'h1);
        data_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            chk("t4_pop", data, 32'(bytes[w]));
            step();
        end
        data_ready = 1'b0;
        chk("t4_empty", 32'(data_valid), 32'h0);

        // 5: simultaneous push and pop on a full FIFO
        pulse_cs();
        for (int w = 0; w < 4; w++) begin
            upd(7, 0); send_byte(bytes[w]);
        end
        upd(7, 0);
        for (int i = 7; i >= 1; i--) begin
            sdi = {3'b000, bytes[4][i]}; step();
        end
        sdi = {3'b000, bytes[4][0]};
        data_ready = 1'b1; step(); data_ready = 1'b0;
        chk("t5_count", 32'(fifo_count), 32'h4);
        chk("t5_ovf", 32'(overflow), 32'h0);
        chk("t5_head", data, 32'h22);

        // 6: chip-select mid quad word
        pulse_cs();
        upd(7, 2);
        for (int n = 0; n < 3; n++) begin
            sdi = 4'(n + 9); step();
        end
        cs = 1'b1; step();
        chk("t6_data", data, 32'h0);
        chk("t6_valid", 32'(data_valid), 32'h0);
        chk("t6_count", 32'(fifo_count), 32'h0);
        chk("t6_ovf", 32'(overflow), 32'h0);
        cs = 1'b0;
        send_byte(8'h3C);
        chk("t6_byte", data, 32'h0000003C);

        // Random traffic: stalled consumer first, then a busier one
        for (int c = 0; c < 3000; c++) begin
            cs             = ($urandom_range(0, 249) == 0);
            counter_in_upd = ($urandom_range(0, 11) == 0);
            counter_in     = CNT_W'($urandom_range(0, 10));
            mode_in        = 2'($urandom_range(0, 3));
            sdi            = 4'($urandom_range(0, 15));
            data_ready     = (c < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            step();
        end
        cs = 1'b0; counter_in_upd = 1'b0; data_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
